gpio_test_monitor: RTL and testbench



---
 rtl/gpio_mon_pkg.sv | 23 ++
 rtl/gpio_mon_filter.sv | 55 +++++
 rtl/gpio_test_monitor.sv | 155 +++++++++++++++
 tb/tb_gpio_test_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mon_pkg.sv
// gpio_mon_pkg: shared types and constants for the GPIO test-status monitor.
//   run_state_e  : monitor verdict state (IDLE, RUN, PASS, FAIL)
//   DEF_*_TAG    : default tag bytes for start and result codes
//   TAG/MASK/RES : bit positions of the code fields on the GPIO bus
package gpio_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } run_state_e;

    localparam logic [7:0] DEF_START_TAG  = 8'hA0;
    localparam logic [7:0] DEF_RESULT_TAG = 8'hAB;

    localparam int TAG_HI  = 15;
    localparam int TAG_LO  = 8;
    localparam int MASK_HI = 7;
    localparam int MASK_LO = 1;
    localparam int RES_BIT = 0;

endpackage

// File: rtl/gpio_mon_filter.sv
// gpio_mon_filter: synchronises the asynchronous GPIO bus and accepts a value
// once it has been seen unchanged for STABLE_CYC consecutive samples and it
// differs from the previously accepted value.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   gpio        : raw bus, asynchronous to clk
//   acc_valid   : high for one cycle when a new value is accepted
//   acc_code    : value being accepted (valid with acc_valid)
module gpio_mon_filter #(
    parameter int GPIO_W     = 16,
    parameter int STABLE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GPIO_W-1:0] gpio,
    output logic              acc_valid,
    output logic [GPIO_W-1:0] acc_code
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [GPIO_W-1:0] sync1, sync2, samp, last_acc;
    logic              last_vld;
    logic [CNT_W-1:0]  stab_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            samp     <= '0;
            last_acc <= '0;
            last_vld <= 1'b0;
            stab_cnt <= '0;
        end else begin
            sync1 <= gpio;
            sync2 <= sync1;
            samp  <= sync2;
            // A change restarts the run at one sample; the count saturates.
            if (sync2 != samp)
                stab_cnt <= CNT_W'(1);
            else if (stab_cnt != CNT_W'(STABLE_CYC))
                stab_cnt <= stab_cnt + CNT_W'(1);
            if (acc_valid) begin
                last_acc <= samp;
                last_vld <= 1'b1;
            end
        end
    end

    // Driven only from registers; the consumer registers it again, so the
    // accept pulse lasts one cycle because last_acc catches up on that edge.
    assign acc_valid = (stab_cnt == CNT_W'(STABLE_CYC)) && (!last_vld || (samp != last_acc));
    assign acc_code  = samp;

endmodule

// File: rtl/gpio_test_monitor.sv
// gpio_test_monitor: decodes firmware test-status codes written on a GPIO bus
// and keeps a sticky verdict with per-test start/pass/fail tracking.
// Optional watchdog built only when GPIO_MON_TIMEOUT_EN is defined; otherwise
// timeout is tied low and IDLE/RUN wait indefinitely.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   gpio              : monitored bus (bits above 15 are carried, not decoded)
//   run_state         : 0 IDLE, 1 RUN, 2 PASS, 3 FAIL
//   started/passed/failed : sticky per-test flags
//   evt_valid/evt_code: one-cycle pulse and held code per recognised code
//   err_proto         : sticky protocol error
//   timeout           : sticky watchdog expiry
module gpio_test_monitor
    import gpio_mon_pkg::*;
#(
    parameter int         GPIO_W      = 16,
    parameter int         N_TESTS     = 3,
    parameter int         FINAL_TEST  = 0,
    parameter logic [7:0] START_TAG   = DEF_START_TAG,
    parameter logic [7:0] RESULT_TAG  = DEF_RESULT_TAG,
    parameter int         STABLE_CYC  = 2,
    parameter int         TIMEOUT_CYC = 30000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [GPIO_W-1:0]  gpio,
    output logic [1:0]         run_state,
    output logic [N_TESTS-1:0] started,
    output logic [N_TESTS-1:0] passed,
    output logic [N_TESTS-1:0] failed,
    output logic               evt_valid,
    output logic [GPIO_W-1:0]  evt_code,
    output logic               err_proto,
    output logic               timeout
);

    if (GPIO_W < 16)                           begin : g_chk_w   $error("GPIO_W must be >= 16"); end
    if (N_TESTS < 1 || N_TESTS > 7)            begin : g_chk_n   $error("N_TESTS must be 1..7"); end
    if (FINAL_TEST < 0 || FINAL_TEST >= N_TESTS) begin : g_chk_f $error("FINAL_TEST out of range"); end
    if (STABLE_CYC < 1)                        begin : g_chk_s   $error("STABLE_CYC must be >= 1"); end
    if (TIMEOUT_CYC < 2)                       begin : g_chk_t   $error("TIMEOUT_CYC must be >= 2"); end

    logic              acc_valid;
    logic [GPIO_W-1:0] acc_code;

    gpio_mon_filter #(
        .GPIO_W    (GPIO_W),
        .STABLE_CYC(STABLE_CYC)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .gpio     (gpio),
        .acc_valid(acc_valid),
        .acc_code (acc_code)
    );

    // ---- decode ----
    logic [7:0]         tag;
    logic [6:0]         mask;
    logic               res;
    logic               is_start, is_evt, mask_ok, wd_expire, frozen;
    logic [N_TESTS-1:0] sel;

    assign tag      = acc_code[TAG_HI:TAG_LO];
    assign mask     = acc_code[MASK_HI:MASK_LO];
    assign res      = acc_code[RES_BIT];
    assign sel      = mask[N_TESTS-1:0];
    assign is_start = (tag == START_TAG);
    assign is_evt   = acc_valid && (is_start || (tag == RESULT_TAG));
    // Exactly one mask bit, and it must select an implemented test.
    assign mask_ok  = $onehot(mask) && ((mask >> N_TESTS) == 7'd0);

    run_state_e         state, state_n;
    logic [N_TESTS-1:0] started_n, passed_n, failed_n;
    logic               err_n, timeout_n;

    assign frozen    = (state == ST_PASS) || (state == ST_FAIL);
    assign run_state = state;

    // ---- watchdog ----
`ifdef GPIO_MON_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (is_evt)
            wd_cnt <= '0;
        else if (!frozen && !wd_expire)
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign wd_expire = 1'b0;
`endif

    // ---- next state ----
    always_comb begin
        state_n   = state;
        started_n = started;
        passed_n  = passed;
        failed_n  = failed;
        err_n     = err_proto;
        timeout_n = timeout;
        if (!frozen) begin
            // An event in the expiry cycle takes priority over the watchdog.
            if (is_evt) begin
                if (!mask_ok) begin
                    err_n = 1'b1;
                end else if (is_start) begin
                    if ((started & sel) != '0) err_n = 1'b1;
                    started_n = started | sel;
                    if (state == ST_IDLE) state_n = ST_RUN;
                end else begin
                    if ((started & sel) == '0) err_n = 1'b1;
                    if (res) begin
                        passed_n = passed | sel;
                        if (sel[FINAL_TEST]) state_n = ST_PASS;
                    end else begin
                        failed_n = failed | sel;
                        state_n  = ST_FAIL;
                    end
                end
            end else if (wd_expire) begin
                timeout_n = 1'b1;
                state_n   = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            started   <= '0;
            passed    <= '0;
            failed    <= '0;
            err_proto <= 1'b0;
            timeout   <= 1'b0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
        end else begin
            state     <= state_n;
            started   <= started_n;
            passed    <= passed_n;
            failed    <= failed_n;
            err_proto <= err_n;
            timeout   <= timeout_n;
            evt_valid <= is_evt;
            if (is_evt) evt_code <= acc_code;
        end
    end

endmodule

// File: tb/tb_gpio_test_monitor.sv
module tb_gpio_test_monitor;
    localparam int GW = 16, NT = 3, FT = 0, SC = 2, TO = 100;

    logic          clk = 1'b0, reset = 1'b1;
    logic [GW-1:0] gpio = '0;
    logic [1:0]    run_state;
    logic [NT-1:0] started, passed, failed;
    logic          evt_valid, err_proto, timeout;
    logic [GW-1:0] evt_code;

    gpio_test_monitor #(
        .GPIO_W(GW), .N_TESTS(NT), .FINAL_TEST(FT), .START_TAG(8'hA0),
        .RESULT_TAG(8'hAB), .STABLE_CYC(SC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .gpio(gpio), .run_state(run_state),
        .started(started), .passed(passed), .failed(failed),
        .evt_valid(evt_valid), .evt_code(evt_code),
        .err_proto(err_proto), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, evt_seen = 0, base = 0;
    bit mon_en = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] code;
        logic [1:0]  st;
        logic [2:0]  sta, pas, fai;
        logic        err;
    } vec_t;
    vec_t tbl[6];

    logic [15:0] rc[8];
    int          rh[8];
    logic [15:0] c, expc;
    int          kind, idx, m_last, k, h, found;
    logic [1:0]  m_st;
    logic [2:0]  m_sta, m_pas, m_fai;
    logic        m_err;
    logic [6:0]  mk;
    logic [7:0]  tg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: outputs sampled on the falling edge; random-mode events are
    // checked in order against the model's queue.
    task automatic step();
        @(negedge clk);
        if (evt_valid) begin
            evt_seen++;
            if (mon_en) begin
                expc = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                chk("rnd_evt_code", 32'(evt_code), 32'(expc));
            end
        end
    endtask

    task automatic apply(input logic [15:0] v, input int n);
        gpio = v;
        repeat (n) step();
    endtask

    task automatic do_reset(input logic [15:0] v);
        @(negedge clk);
        reset = 1'b1;
        gpio  = v;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_vec(input string tagn, input logic [1:0] st, input logic [2:0] sta,
                           input logic [2:0] pas, input logic [2:0] fai, input logic err);
        chk({tagn, "_state"}, 32'(run_state), 32'(st));
        chk({tagn, "_started"}, 32'(started), 32'(sta));
        chk({tagn, "_passed"}, 32'(passed), 32'(pas));
        chk({tagn, "_failed"}, 32'(failed), 32'(fai));
        chk({tagn, "_err"}, 32'(err_proto), 32'(err));
    endtask

    initial begin
        tbl[0] = '{16'hA008, 2'd1, 3'b100, 3'b000, 3'b000, 1'b0};
        tbl[1] = '{16'hAB09, 2'd1, 3'b100, 3'b100, 3'b000, 1'b0};
        tbl[2] = '{16'hA004, 2'd1, 3'b110, 3'b100, 3'b000, 1'b0};
        tbl[3] = '{16'hAB05, 2'd1, 3'b110, 3'b110, 3'b000, 1'b0};
        tbl[4] = '{16'hA002, 2'd1, 3'b111, 3'b110, 3'b000, 1'b0};
        tbl[5] = '{16'hAB03, 2'd2, 3'b111, 3'b111, 3'b000, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk_vec("rst", 2'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_code", 32'(evt_code), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;

        // nominal sequence, table driven
        do_reset(16'h0000);
        base = evt_seen;
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].code, 10);
            chk_vec($sformatf("nom%0d", i), tbl[i].st, tbl[i].sta, tbl[i].pas, tbl[i].fai, tbl[i].err);
        end
        chk("nom_evt_count", 32'(evt_seen - base), 6);
        chk("nom_evt_code", 32'(evt_code), 32'h0000AB03);

        // fail, then a later pass is reported but not recorded
        do_reset(16'hA008);
        apply(16'hA008, 10);
        apply(16'hAB08, 10);
        chk_vec("fail", 2'd3, 3'b100, 3'b000, 3'b100, 1'b0);
        base = evt_seen;
        apply(16'hAB09, 10);
        chk("fail_late_evt", 32'(evt_seen - base), 1);
        chk("fail_late_code", 32'(evt_code), 32'h0000AB09);
        chk_vec("fail_frozen", 2'd3, 3'b100, 3'b000, 3'b100, 1'b0);

        // glitch inside a steady code
        do_reset(16'hA002);
        apply(16'hA002, 10);
        base = evt_seen;
        apply(16'hAB02, 1);
        apply(16'hA002, 10);
        apply(16'hA002, 10);
        chk("glitch_evt", 32'(evt_seen - base), 0);
        chk_vec("glitch", 2'd1, 3'b001, 3'b000, 3'b000, 1'b0);

        // protocol errors
        do_reset(16'hAB05);
        apply(16'hAB05, 10);
        chk_vec("proto_nostart", 2'd0, 3'b000, 3'b010, 3'b000, 1'b1);
        do_reset(16'hA00C);
        base = evt_seen;
        apply(16'hA00C, 10);
        chk_vec("proto_mask", 2'd0, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("proto_mask_evt", 32'(evt_seen - base), 1);

        // latency: code set before edge 0, pulse after edge 2+STABLE_CYC only
        do_reset(16'h0000);
        apply(16'h0000, 8);
        gpio = 16'hA004;
        for (int e = 0; e <= 5; e++) begin
            step();
            chk($sformatf("lat_e%0d", e), 32'(evt_valid), (e == 2 + SC) ? 1 : 0);
        end
        chk("lat_state", 32'(run_state), 1);

        // asynchronous reset mid-run, then re-acceptance of the held code
        do_reset(16'hA002);
        apply(16'hA002, 10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_vec("mid_rst", 2'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("mid_rst_code", 32'(evt_code), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            step();
            chk($sformatf("rel_e%0d", e), 32'(evt_valid), (e == 2 + SC) ? 1 : 0);
        end
        chk("rel_started", 32'(started), 1);

        // watchdog
`ifdef GPIO_MON_TIMEOUT_EN
        do_reset(16'hA002);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (evt_valid) found = 1;
        end
        chk("wd_accept", 32'(found), 1);
        repeat (TO - 1) step();
        chk("wd_before", 32'(timeout), 0);
        chk("wd_before_st", 32'(run_state), 1);
        step();
        chk("wd_expire", 32'(timeout), 1);
        chk("wd_expire_st", 32'(run_state), 3);
        do_reset(16'hA002);
        for (int i = 0; i < 6; i++) apply((i % 2) ? 16'hA004 : 16'hA002, 90);
        chk("wd_kick", 32'(timeout), 0);
        chk("wd_kick_st", 32'(run_state), 1);
`else
        do_reset(16'hA002);
        apply(16'hA002, 300);
        chk("wd_off", 32'(timeout), 0);
        chk("wd_off_st", 32'(run_state), 1);
`endif

        // randomized rounds against a code-level reference model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 8; i++) begin
                do begin
                    kind = $urandom_range(0, 7);
                    idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
                    if (kind < 3)      c = {8'hA0, 8'(1 << (idx + 1))};
                    else if (kind < 6) c = {8'hAB, 8'(1 << (idx + 1)) | 8'($urandom_range(0, 1))};
                    else if (kind == 6) c = {8'($urandom_range(16, 159)), 8'($urandom_range(0, 255))};
                    else               c = {($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hAB, 8'($urandom_range(0, 255))};
                end while (i > 0 && c == rc[i-1]);
                rc[i] = c;
                rh[i] = $urandom_range(1, 9);
            end
            exp_q.delete();
            m_last = -1; m_st = 0; m_sta = 0; m_pas = 0; m_fai = 0; m_err = 0;
            for (int i = 0; i < 8; i++) begin
                h = rh[i] + ((i == 7) ? 8 : 0);
                if (h >= SC && int'(rc[i]) != m_last) begin
                    m_last = int'(rc[i]);
                    tg = rc[i][15:8];
                    if (tg == 8'hA0 || tg == 8'hAB) begin
                        exp_q.push_back(rc[i]);
                        if (m_st < 2) begin
                            mk = rc[i][7:1];
                            k = 0;
                            for (int b = 0; b < 7; b++) if (mk[b]) k = b;
                            if (mk == 0 || (mk & (mk - 7'd1)) != 0 || k >= NT) m_err = 1;
                            else if (tg == 8'hA0) begin
                                if (m_sta[k]) m_err = 1;
                                m_sta[k] = 1;
                                if (m_st == 0) m_st = 1;
                            end else begin
                                if (!m_sta[k]) m_err = 1;
                                if (rc[i][0]) begin
                                    m_pas[k] = 1;
                                    if (k == FT) m_st = 2;
                                end else begin
                                    m_fai[k] = 1;
                                    m_st = 3;
                                end
                            end
                        end
                    end
                end
            end
            do_reset(rc[0]);
            mon_en = 1;
            for (int i = 0; i < 8; i++) apply(rc[i], rh[i]);
            repeat (8) step();
            mon_en = 0;
            chk("rnd_evt_left", 32'(exp_q.size()), 0);
            chk_vec($sformatf("rnd%0d", r), m_st, m_sta, m_pas, m_fai, m_err);
            chk("rnd_timeout", 32'(timeout), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
